// File: rtl/order_ingress_queue_if.sv
// Upstream order handshake bundle for order_ingress_queue.
// The host side drives valid/side/word; the queue answers with ready.
interface order_ingress_queue_if;
  logic        s_valid;
  logic        s_ready;
  logic        s_is_buy;
  logic [31:0] s_data;

  modport master (
    output s_valid,
    output s_is_buy,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_is_buy,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/order_ingress_queue.sv
// Order FIFO feeding the matching engine one order at a time.
// Optional zero-quantity rejection under ZERO_QTY_FILTER_EN.
module order_ingress_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  order_ingress_queue_if.slave s,
  output logic                m_valid,
  output logic                m_is_buy,
  output logic [31:0]         m_data,
  input  logic                engine_busy,
  output logic [ADDR_W:0]     occupancy,
  output logic                ack_timeout_err,
  output logic [15:0]         reject_cnt
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      TMO  = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [32:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [7:0]        tmo_cnt;
  logic [7:0]        tmo_nxt;
  logic              accept;
  logic              push;
  logic              pop;
  logic              err_set;

  // Ready looks only at the stored count, never at a same-cycle pop.
  assign s.s_ready = !rst && (count != FULL);
  assign accept    = s.s_valid && s.s_ready;
  assign occupancy = count;

`ifdef ZERO_QTY_FILTER_EN
  logic zero_qty;

  assign zero_qty = (s.s_data[14:0] == 15'd0);
  assign push     = accept && !zero_qty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_cnt <= 16'd0;
    end else if (accept && zero_qty && reject_cnt != 16'hFFFF) begin
      reject_cnt <= reject_cnt + 16'd1;
    end
  end
`else
  assign push       = accept;
  assign reject_cnt = 16'd0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s.s_is_buy, s.s_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    pop       = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && !engine_busy) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tmo_nxt   = 8'd0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (engine_busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
          // A silent engine consumes the order; it is not re-sent.
          if (tmo_nxt == TMO) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!engine_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tmo_cnt         <= 8'd0;
      m_valid         <= 1'b0;
      m_is_buy        <= 1'b0;
      m_data          <= 32'd0;
      ack_timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      m_valid <= pop;
      if (pop) begin
        {m_is_buy, m_data} <= mem[rd_ptr];
      end
      if (err_set) ack_timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/order_ingress_queue.md
Name: order_ingress_queue

Overview:
Upstream stage of order_book_top. Buffers incoming orders from the host/packet side in a FIFO. Dispatches them one at a time to the matching engine using its input_valid / engine_busy handshake: a one-cycle valid pulse, then wait for busy to rise and fall. Optionally rejects zero-quantity orders before they reach the book.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
ADDR_W, 4, log2(DEPTH).
ACK_TIMEOUT, 15, max cycles to wait for engine_busy to rise after a dispatch pulse; 1..255.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
s_valid  in  1  upstream order present.
s_ready  out  1  queue can accept; transfer when s_valid && s_ready at rising edge.
s_is_buy  in  1  side: 1=buy/bid, 0=sell/ask.
s_data  in  32  order word {price[31:16], is_bot[15], qty[14:0]}.
m_valid  out  1  to engine input_valid; single-cycle pulse per order.
m_is_buy  out  1  to engine input_is_buy; held from pulse until next dispatch.
m_data  out  32  to engine input_data; held like m_is_buy.
engine_busy  in  1  from engine.
occupancy  out  ADDR_W+1  entries currently stored, 0..DEPTH.
ack_timeout_err  out  1  sticky; set when the engine fails to raise busy within ACK_TIMEOUT.
reject_cnt  out  16  saturating count of rejected orders.

Behaviour:
- Reset: asynchronous, active-high. Takes effect immediately, mid-dispatch included.
  - FIFO emptied; occupancy=0; s_ready=0 while rst is high and 1 on the first cycle after release.
  - m_valid=0, m_is_buy=0, m_data=0, ack_timeout_err=0, reject_cnt=0, FSM=IDLE, timeout counter=0.
- FIFO storage: 33 bits per entry ({is_buy, data}). Circular read/write pointers of ADDR_W bits wrap DEPTH-1 -> 0. Count register is ADDR_W+1 bits.
- Ready and push rules:
  - s_ready = (occupancy != DEPTH), registered count only; a pop in the same cycle does not free space.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- FSM, one dispatch in flight at a time:
  - IDLE: if occupancy!=0 and engine_busy==0, load head into m_is_buy/m_data, assert m_valid, pop FIFO, go to ISSUE.
  - ISSUE (m_valid=1 this cycle only): go to WAIT_ACK. Clear timeout counter.
  - WAIT_ACK: if engine_busy==1, go to WAIT_DONE. Otherwise increment counter. When counter==ACK_TIMEOUT, set ack_timeout_err and go to IDLE; the order is treated as consumed, not re-sent.
  - WAIT_DONE: when engine_busy==0, go to IDLE.
- Latency: order accepted at edge E into an empty queue with engine idle -> m_valid high in the cycle following edge E+1.
- Back-to-back: minimum 1 IDLE cycle between a busy falling edge and the next m_valid pulse.
- engine_busy already high in IDLE: no dispatch until it drops.
- occupancy counts stored entries only. The in-flight order is not counted.
- reject_cnt saturates at 0xFFFF.
- ack_timeout_err clears only on rst.

Optional Feature:
Macro ZERO_QTY_FILTER_EN.
- Defined: an accepted order with qty[14:0]==0 is handshaken normally (s_ready honoured) but not written to the FIFO, and reject_cnt increments.
- Not defined: zero-qty orders are queued and dispatched like any other, and reject_cnt is tied to 0.

Test Plan:
1. Reset then single order: sell price 105, qty 50, bot=1 -> m_valid pulse one cycle after edge E+1, m_data=0x0069_8032, m_is_buy=0. Engine busy for 4 cycles, then queue returns to IDLE; occupancy 1 -> 0.
2. Burst of 17 orders (prices 100..116) with engine_busy forced high -> s_ready drops after 16, occupancy=16. Release busy: orders dispatch in FIFO order 100..115. The 17th is accepted once space frees, and pointer wrap is exercised.
3. Engine_busy held low after a dispatch (no ack) -> ack_timeout_err=1 after 15 WAIT_ACK cycles. Next queued order still dispatches; error stays set until rst.
4. rst asserted during WAIT_DONE with 3 entries queued -> m_valid=0 immediately, occupancy=0. After release, no dispatch occurs until a new push.
5. With ZERO_QTY_FILTER_EN: push buy 100 qty 0, then buy 100 qty 10 -> reject_cnt=1, only qty 10 dispatched. Without the macro: both dispatched, reject_cnt=0.
6. Simultaneous push and pop with occupancy=4 -> occupancy stays 4, and dispatched data matches the FIFO head.
